// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin hold arbiter.
package arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_t;

    localparam int DEF_N        = 4;
    localparam int DEF_MAX_HOLD = 8;

    // One-hot vector for a requester index; wide enough for the largest N (16).
    function automatic logic [15:0] onehot_of(input logic [3:0] idx);
        logic [15:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating priority encoder: first set request at or after ptr, with wrap.
module rr_priority_pick #(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           valid,
    output logic [IDW-1:0] idx
);

    // Scan from the farthest offset down to ptr so the nearest request wins last.
    always_comb begin : pick
        int pos;
        valid = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (req[pos[IDW-1:0]]) begin
                valid = 1'b1;
                idx   = pos[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter: grants one requester, holds until done or a hold timeout.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no owner; a pending request is granted at the next edge
//   ST_HOLD | owner granted; wait for done, force release at MAX_HOLD
module rr_hold_arbiter
    import arb_pkg::*;
#(
    parameter  int N        = DEF_N,
    parameter  int MAX_HOLD = DEF_MAX_HOLD,
    localparam int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           done,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           timeout,
    output logic           timeout_seen
);

    arb_state_t     state, state_next;
    logic [IDW-1:0] ptr, ptr_next;
    logic [IDW-1:0] id_next;
    logic [7:0]     hold_cnt, hold_cnt_next;
    logic [N-1:0]   gnt_next;
    logic           timeout_next;
    logic           seen_next;
    logic           pick_valid;
    logic [IDW-1:0] pick_idx;

    rr_priority_pick #(.N(N)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Next-state, grant and flag decisions; every output is registered below.
    always_comb begin
        state_next    = state;
        ptr_next      = ptr;
        id_next       = gnt_id;
        hold_cnt_next = hold_cnt;
        timeout_next  = 1'b0;
        seen_next     = timeout_seen;
        gnt_next      = '0;

        unique case (state)
            ST_IDLE: begin
                id_next = '0;
                if (pick_valid) begin
                    state_next    = ST_HOLD;
                    id_next       = pick_idx;
                    hold_cnt_next = 8'd1;
                end
            end
            ST_HOLD: begin
                if (done || (hold_cnt == 8'(MAX_HOLD))) begin
                    // done takes priority: a release on the last hold cycle is not a timeout
                    state_next    = ST_IDLE;
                    id_next       = '0;
                    hold_cnt_next = 8'd0;
                    ptr_next      = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;
                    if (!done) begin
                        timeout_next = 1'b1;
                        seen_next    = 1'b1;
                    end
                end else begin
                    hold_cnt_next = hold_cnt + 8'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                id_next    = '0;
            end
        endcase

        if (state_next == ST_HOLD) begin
            gnt_next = N'(onehot_of(4'(id_next)));
        end
    end

    // State, pointer, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            hold_cnt     <= 8'd0;
            gnt          <= '0;
            gnt_id       <= '0;
            timeout      <= 1'b0;
            timeout_seen <= 1'b0;
        end else begin
            state        <= state_next;
            ptr          <= ptr_next;
            hold_cnt     <= hold_cnt_next;
            gnt          <= gnt_next;
            gnt_id       <= id_next;
            timeout      <= timeout_next;
            timeout_seen <= seen_next;
        end
    end

    assign busy = |gnt;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Randomized and directed bench for rr_hold_arbiter against a behavioural model.
module tb_rr_hold_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;
    localparam int IDW      = $clog2(N);

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic           done;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           timeout;
    logic           timeout_seen;

    int n_checks;
    int n_fail;

    // Reference model: owner index (-1 when free), cycles held, next scan start, flags.
    int m_owner;
    int m_held;
    int m_ptr;
    bit m_timeout;
    bit m_seen;

    rr_hold_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .done         (done),
        .gnt          (gnt),
        .gnt_id       (gnt_id),
        .busy         (busy),
        .timeout      (timeout),
        .timeout_seen (timeout_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_held    = 0;
        m_ptr     = 0;
        m_timeout = 1'b0;
        m_seen    = 1'b0;
    endtask

    // One clock of the arbitration rules, applied to the values driven for this edge.
    task automatic model_step(input logic [N-1:0] r, input logic d);
        m_timeout = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && r[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_held  = 1;
                end
            end
        end else if (d) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_held  = 0;
        end else if (m_held == MAX_HOLD) begin
            m_ptr     = (m_owner + 1) % N;
            m_owner   = -1;
            m_held    = 0;
            m_timeout = 1'b1;
            m_seen    = 1'b1;
        end else begin
            m_held++;
        end
    endtask

    task automatic check_outputs();
        int exp_gnt;
        exp_gnt = (m_owner < 0) ? 0 : (1 << m_owner);
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("gnt_id", 32'(gnt_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
        check("busy", 32'(busy), (m_owner < 0) ? 32'd0 : 32'd1);
        check("timeout", 32'(timeout), 32'(m_timeout));
        check("timeout_seen", 32'(timeout_seen), 32'(m_seen));
    endtask

    task automatic cyc(input logic [N-1:0] r, input logic d);
        @(negedge clk);
        req  = r;
        done = d;
        model_step(r, d);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_gnt_id"}, 32'(gnt_id), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
        check({tag, "_seen"}, 32'(timeout_seen), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        req      = '0;
        done     = 1'b0;
        model_reset();
        #1;
        check_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single request from requester 2, released by done three edges later.
        cyc(4'b0100, 1'b0);
        check("single_gnt", 32'(gnt), 32'h4);
        check("single_id", 32'(gnt_id), 32'd2);
        cyc(4'b0000, 1'b0);
        cyc(4'b0000, 1'b0);
        cyc(4'b0000, 1'b1);
        check("single_release", 32'(gnt), 32'd0);
        cyc(4'b0000, 1'b0);

        // Fairness: all requesting, done one cycle after each grant.
        for (int i = 0; i < 5; i++) begin
            cyc(4'b1111, 1'b0);
            check("rr_busy", 32'(busy), 32'd1);
            cyc(4'b1111, 1'b1);
            check("rr_turnaround", 32'(gnt), 32'd0);
        end
        cyc(4'b0000, 1'b0);

        // Timeout on requester 0 with done held low.
        cyc(4'b0001, 1'b0);
        for (int i = 0; i < MAX_HOLD; i++) begin
            cyc(4'b0000, 1'b0);
        end
        check("to_pulse", 32'(timeout), 32'd1);
        check("to_gnt", 32'(gnt), 32'd0);
        cyc(4'b0000, 1'b0);
        check("to_pulse_end", 32'(timeout), 32'd0);
        check("to_sticky", 32'(timeout_seen), 32'd1);

        // done on the last allowed hold cycle: release without a timeout.
        cyc(4'b0010, 1'b0);
        for (int i = 0; i < MAX_HOLD - 1; i++) begin
            cyc(4'b0000, 1'b0);
        end
        cyc(4'b0000, 1'b1);
        check("edge_done_to", 32'(timeout), 32'd0);
        check("edge_done_gnt", 32'(gnt), 32'd0);

        // Owner drops request, another requests during hold.
        cyc(4'b0000, 1'b0);
        cyc(4'b0010, 1'b0);
        cyc(4'b1000, 1'b0);
        cyc(4'b1000, 1'b0);
        check("drop_hold", 32'(gnt), 32'h2);
        cyc(4'b1000, 1'b1);
        cyc(4'b1000, 1'b0);
        check("drop_next", 32'(gnt), 32'h8);
        cyc(4'b0000, 1'b1);

        // Randomized traffic with mixed done rates to exercise timeouts.
        for (int i = 0; i < 600; i++) begin
            logic [N-1:0] r;
            logic         d;
            r = N'($urandom_range(0, (1 << N) - 1));
            if ($urandom_range(0, 3) == 0) r = '0;
            if (i < 300) d = ($urandom_range(0, 9) < 3);
            else         d = ($urandom_range(0, 19) == 0);
            cyc(r, d);
        end

        // Mid-grant asynchronous reset with timeout_seen already set.
        cyc(4'b0000, 1'b1);
        cyc(4'b0000, 1'b0);
        cyc(4'b0100, 1'b0);
        for (int i = 0; i < MAX_HOLD; i++) begin
            cyc(4'b0100, 1'b0);
        end
        cyc(4'b0100, 1'b0);
        cyc(4'b0100, 1'b0);
        check("pre_rst_gnt", 32'(gnt), 32'h4);
        check("pre_rst_seen", 32'(timeout_seen), 32'd1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc(4'b0100, 1'b0);
        check("post_rst_gnt", 32'(gnt), 32'h4);
        cyc(4'b0100, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
